// File: rtl/sbox_inv_step1_masked.sv
`default_nettype none
// ============================================================================
// Module   : sbox_inv_step1_masked
// Brief    : 2-share masked AES inverse-affine input stage with remask and
//            elastic valid/ready pipeline feeding the masked inversion gadget.
// Revision : 1.0
// ============================================================================
module sbox_inv_step1_masked #(
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in0,
    input  logic [7:0]       in1,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       r,
    output logic [7:0]       out0,
    output logic [7:0]       out1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] acc_cnt
);

    localparam logic [7:0] C_INV_AFF = 8'h05;

    logic [7:0]             w_lin0;
    logic [7:0]             w_lin1;
    logic [STAGES-1:0]      r_v;
    logic [STAGES-1:0][7:0] r_s0;
    logic [STAGES-1:0][7:0] r_s1;
    logic [STAGES-1:0]      w_ready;
    logic [STAGES-1:0]      w_vin;
    logic [STAGES-1:0][7:0] w_din0;
    logic [STAGES-1:0][7:0] w_din1;
    logic [CNT_W-1:0]       r_cnt;

    // Linear part of InvAffine, one independent cone per share.
    for (genvar i = 0; i < 8; i++) begin : g_lin
        assign w_lin0[i] = in0[(i + 2) % 8] ^ in0[(i + 5) % 8] ^ in0[(i + 7) % 8];
        assign w_lin1[i] = in1[(i + 2) % 8] ^ in1[(i + 5) % 8] ^ in1[(i + 7) % 8];
    end

    // A stage can take data if it or any stage downstream has a hole.
    for (genvar k = 0; k < STAGES; k++) begin : g_ready
        assign w_ready[k] = out_ready | ~(&r_v[STAGES-1:k]);
    end

    always_comb begin
        w_vin     = '0;
        w_din0    = '0;
        w_din1    = '0;
        w_vin[0]  = in_valid;
        w_din0[0] = w_lin0 ^ C_INV_AFF ^ r;
        w_din1[0] = w_lin1 ^ r;
        for (int k = 1; k < STAGES; k++) begin
            w_vin[k]  = r_v[k-1];
            w_din0[k] = r_s0[k-1];
            w_din1[k] = r_s1[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v  <= '0;
            r_s0 <= '0;
            r_s1 <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ready[k]) begin
                    r_v[k] <= w_vin[k];
                end
                // Share registers toggle only on a real transfer.
                if (w_ready[k] && w_vin[k]) begin
                    r_s0[k] <= w_din0[k];
                    r_s1[k] <= w_din1[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (in_valid && w_ready[0]) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign in_ready  = w_ready[0];
    assign out_valid = r_v[STAGES-1];
    assign out0      = r_s0[STAGES-1];
    assign out1      = r_s1[STAGES-1];
    assign acc_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sbox_inv_step1_masked.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbox_inv_step1_masked
// Brief    : Directed self-checking bench for sbox_inv_step1_masked
//            (STAGES=2/CNT_W=16, STAGES=1/CNT_W=4, STAGES=4/CNT_W=16).
// Revision : 1.0
// ============================================================================
module tb_sbox_inv_step1_masked;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [7:0]       in0, in1, r;
    logic [2:0]       iv, ordy, irdy, ov;
    logic [2:0][7:0]  o0, o1;
    logic [15:0]      cnt_a, cnt_c;
    logic [3:0]       cnt_b;

    int checks = 0;
    int errors = 0;
    int j, got;
    int idx [16];
    logic [7:0] ys [16];
    logic [7:0] xs [16];
    logic [7:0] m, hold0, hold1;

    sbox_inv_step1_masked #(.STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1), .in_valid(iv[0]),
        .in_ready(irdy[0]), .r(r), .out0(o0[0]), .out1(o1[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .acc_cnt(cnt_a)
    );

    sbox_inv_step1_masked #(.STAGES(1), .CNT_W(4)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1), .in_valid(iv[1]),
        .in_ready(irdy[1]), .r(r), .out0(o0[1]), .out1(o1[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .acc_cnt(cnt_b)
    );

    sbox_inv_step1_masked #(.STAGES(4), .CNT_W(16)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1), .in_valid(iv[2]),
        .in_ready(irdy[2]), .r(r), .out0(o0[2]), .out1(o1[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .acc_cnt(cnt_c)
    );

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
        end
    endtask

    // Reference written as the textbook rotation form of the inverse affine map.
    function automatic logic [7:0] rotl(input logic [7:0] a, input int k);
        return (a << k) | (a >> (8 - k));
    endfunction

    function automatic logic [7:0] inv_aff(input logic [7:0] y);
        return rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input int n);
        m   = 8'($urandom);
        in0 = ys[n] ^ m;
        in1 = m;
        r   = 8'($urandom);
    endtask

    // One isolated byte on instance d; checks acceptance, latency and unmasked value.
    task automatic run_one(input int d, input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] rr, input logic [7:0] exp_x,
                           input int exp_lat, input string tag);
        int lat;
        @(negedge clk);
        in0 = a0; in1 = a1; r = rr; iv[d] = 1'b1;
        check({tag, "_rdy"}, 32'(irdy[d]), 32'd1);
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            iv[d] = 1'b0;
            if (ov[d]) begin
                lat = n;
                break;
            end
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_x"}, 32'(o0[d] ^ o1[d]), 32'(exp_x));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; iv = '0; ordy = 3'b111;
        in0 = '0; in1 = '0; r = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ov", 32'(ov[0]), 32'd0);
        check("rst_o0", 32'(o0[0]), 32'd0);
        check("rst_o1", 32'(o1[0]), 32'd0);
        check("rst_rdy", 32'(irdy[0]), 32'd1);
        check("rst_cnt", 32'(cnt_a), 32'd0);
        check("rst_ov_s1s4", 32'({ov[1], ov[2]}), 32'd0);
        rst_n = 1'b1;

        // y=0x63 -> 0x00; share 1 alone must be L(0xA5)^r = 0x0F^0x3C
        run_one(0, 8'hC6, 8'hA5, 8'h3C, 8'h00, 2, "v63");
        check("v63_out1", 32'(o1[0]), 32'h33);
        run_one(0, 8'h6D, 8'h11, 8'h00, 8'h01, 2, "v7c");

        for (int y = 0; y < 256; y++) begin
            m = 8'($urandom);
            run_one(0, 8'(y) ^ m, m, 8'($urandom), inv_aff(8'(y)), 2,
                    $sformatf("sweep_%02h", y));
        end

        // Back-to-back 8 bytes at full rate.
        do_reset();
        for (int n = 0; n < 8; n++) begin
            ys[n] = 8'(n * 29 + 3);
            xs[n] = inv_aff(ys[n]);
        end
        got = 0;
        fork
            begin
                for (int n = 0; n < 8; n++) begin
                    @(negedge clk);
                    drive(n);
                    iv[0] = 1'b1;
                end
                @(negedge clk);
                iv[0] = 1'b0;
            end
            begin
                for (int c = 0; c < 30 && got < 8; c++) begin
                    @(negedge clk);
                    if (ov[0]) begin
                        check($sformatf("b2b_%0d", got), 32'(o0[0] ^ o1[0]), 32'(xs[got]));
                        idx[got] = c;
                        got++;
                    end
                end
            end
        join
        check("b2b_count", got, 8);
        check("b2b_consecutive", idx[7] - idx[0], 7);
        check("b2b_acc", 32'(cnt_a), 32'd8);

        // Stall: fill with out_ready low, then drain in order.
        do_reset();
        for (int n = 0; n < 5; n++) begin
            ys[n] = 8'(n * 75 + 17);
            xs[n] = inv_aff(ys[n]);
        end
        ordy[0] = 1'b0;
        @(negedge clk);
        j = 0;
        drive(0);
        iv[0] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (irdy[0]) begin
                j++;
                @(negedge clk);
                drive(j);
            end else begin
                @(negedge clk);
            end
        end
        check("stall_accepts", j, 2);
        check("stall_rdy", 32'(irdy[0]), 32'd0);
        check("stall_ov", 32'(ov[0]), 32'd1);
        check("stall_x0", 32'(o0[0] ^ o1[0]), 32'(xs[0]));
        hold0 = o0[0];
        hold1 = o1[0];
        repeat (3) @(negedge clk);
        check("stall_hold", 32'({ov[0], o0[0], o1[0]}), 32'({1'b1, hold0, hold1}));
        ordy[0] = 1'b1;
        got = 0;
        fork
            begin
                for (int c = 0; c < 20 && j < 5; c++) begin
                    #1;
                    if (irdy[0]) begin
                        j++;
                        @(negedge clk);
                        if (j < 5) drive(j);
                        else iv[0] = 1'b0;
                    end else begin
                        @(negedge clk);
                    end
                end
            end
            begin
                for (int c = 0; c < 30 && got < 5; c++) begin
                    #2;
                    if (ov[0]) begin
                        check($sformatf("drain_%0d", got), 32'(o0[0] ^ o1[0]), 32'(xs[got]));
                        got++;
                    end
                    @(negedge clk);
                end
            end
        join
        repeat (3) @(negedge clk);
        check("drain_count", got, 5);
        check("drain_empty", 32'(ov[0]), 32'd0);
        check("drain_acc", 32'(cnt_a), 32'd5);

        // Asynchronous reset with two bytes in flight.
        do_reset();
        @(negedge clk); drive(0); iv[0] = 1'b1;
        @(negedge clk); drive(1);
        @(negedge clk); iv[0] = 1'b0;
        check("inflight_ov", 32'(ov[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_ov", 32'(ov[0]), 32'd0);
        check("arst_out", 32'({o0[0], o1[0]}), 32'd0);
        check("arst_cnt", 32'(cnt_a), 32'd0);
        check("arst_rdy", 32'(irdy[0]), 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        run_one(0, 8'h9A, 8'h5B, 8'h77, inv_aff(8'hC1), 2, "post_rst");
        check("post_rst_cnt", 32'(cnt_a), 32'd1);

        // Other depths; 4-bit counter wrap after 17 accepts.
        do_reset();
        run_one(1, 8'h3C, 8'h3C, 8'hC3, 8'h05, 1, "s1");
        run_one(2, 8'hF0, 8'h0F, 8'h5A, 8'hFA, 4, "s4");
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            in0 = 8'($urandom); in1 = 8'($urandom); r = 8'($urandom);
            iv[1] = 1'b1;
        end
        @(negedge clk);
        iv[1] = 1'b0;
        @(negedge clk);
        check("cnt_wrap", 32'(cnt_b), 32'd1);
        check("s4_cnt", 32'(cnt_c), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sbox_inv_step1_masked.md
Name: sbox_inv_step1_masked

Overview:
- First stage of the 2-share masked AES inverse S-box. It is the mirror of the forward S-box output stage, which applies the forward affine map after the GF(2^8) inversion gadget.
- This block takes a 2-share masked ciphertext byte, applies the inverse affine transform share-wise, and adds the constant to share 0 only.
- It then remasks both shares with a fresh random byte and passes the result through an elastic valid/ready pipeline.
- Its output feeds the masked inversion gadget.

Parameters:
- STAGES, 2, number of elastic pipeline register stages (legal 1..4). Remask happens at stage 1.
- CNT_W, 16, width of the accepted-byte counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in0  input  8  share 0 of masked byte y.
- in1  input  8  share 1 of masked byte y.
- in_valid  input  1  in0/in1/r valid.
- in_ready  output  1  block accepts input this cycle.
- r  input  8  fresh randomness, consumed together with in0/in1.
- out0  output  8  share 0 of x = InvAffine(y).
- out1  output  8  share 1 of x.
- out_valid  output  1  out0/out1 valid.
- out_ready  input  1  downstream accepts.
- acc_cnt  output  CNT_W  number of accepted input bytes, wraps.

Behaviour:
- Linear map L, applied identically to each share: b_i = a_((i+2)%8) ^ a_((i+5)%8) ^ a_((i+7)%8), bit index 0 = LSB.
- Constant 0x05 is XORed into share 0 only. Share 1 never receives a constant.
- Stage-1 register on accept: s0 <= L(in0) ^ 0x05 ^ r, and s1 <= L(in1) ^ r.
- Stages 2..STAGES are plain share-wise copies; there is no logic between shares.
- Shares are never combined in any combinational cone. Each register holds exactly one share.
- Functional invariant: out0 ^ out1 = InvAffine(in0 ^ in1) for the corresponding input.
- Elastic pipeline, one valid bit v[k] per stage. Stage k ready_k = !v[k] | ready_(k+1), with ready_(STAGES+1) = out_ready.
- in_ready = ready_1. This is combinational from out_ready through the chain; no skid buffer.
- Transfer at each boundary happens when valid & ready. A stage whose data moves on and receives no new data clears its valid.
- out_valid = v[STAGES]; out0/out1 = last-stage registers.
- Latency is STAGES cycles from accept to out_valid when out_ready is held high. Throughput is 1 byte/cycle.
- Stall: while out_valid=1 and out_ready=0, out0/out1/out_valid hold stable.
- Stall with bubbles: stages holding bubbles keep accepting until the pipeline is full. in_ready drops only once all STAGES valid bits are set.
- Data registers load only on transfer, never on idle cycles. This avoids gratuitous share transitions.
- acc_cnt increments on every in_valid & in_ready. It wraps from 2^CNT_W-1 to 0.
- Reset (rst_n=0, asynchronous, at any time including mid-stream): all v <= 0, all share registers <= 0x00, acc_cnt <= 0. Gives out_valid=0, out0=out1=0x00, in_ready=1.
- In-flight bytes are discarded on reset. The first accept after rst_n rises is on the first clk edge with in_valid=1.
- in_valid with no ready: the upstream must hold in0/in1/r. r counts as consumed only on accept.

Test Plan:
- STAGES=2, out_ready=1; in0=0x63^0xA5, in1=0xA5, r=0x3C -> after 2 cycles out_valid=1, out0^out1=0x00, and out1=L(0xA5)^0x3C.
- Single accept of y=0x7C split as 0x7C^0x11 / 0x11, r=0x00 -> out0^out1=0x01. Then sweep all 256 y with random masks and r, checking XOR against the InvAffine reference model.
- Back-to-back 8 bytes, out_ready=1 -> 8 consecutive out_valid cycles in order, acc_cnt=8.
- Hold out_ready=0 and stream inputs -> in_ready drops after exactly STAGES accepts, and outputs stay stable. Release -> data drains in order with none lost or duplicated.
- Assert rst_n=0 asynchronously mid-stream with 2 bytes in flight -> immediately out_valid=0, out0=out1=0x00, acc_cnt=0, in_ready=1. Next byte after release emerges with correct latency.
- CNT_W=4: accept 17 bytes -> acc_cnt=1. Also run STAGES=1 and STAGES=4 -> latency 1 and 4 respectively.
